// File: rtl/alu_pkg.sv
// Shared types for the ALU op sequencer: opcode width, ALU opcode names
// and the sequencer FSM states.
package alu_pkg;

  localparam int unsigned ALU_OP_W = 4;

  // Legal ALU opcodes; any code with bit 3 set is illegal.
  typedef enum logic [ALU_OP_W-1:0] {
    AND = 4'd0,
    OR  = 4'd1,
    XOR = 4'd2,
    NOR = 4'd3,
    ADD = 4'd4,
    SUB = 4'd5,
    INC = 4'd6,
    DEC = 4'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } seq_state_e;

endpackage : alu_pkg

// File: rtl/alu_seq_regfile.sv
// Register file for the ALU op sequencer: NREGS x DW entries, two
// asynchronous read ports, one synchronous write port. Entry 0 reads as
// zero and ignores writes. Asynchronous active-low clear of all entries.
module alu_seq_regfile #(
  parameter int unsigned DW    = 32,
  parameter int unsigned NREGS = 8,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr1,
  input  logic [AW-1:0] i_raddr2,
  output logic [DW-1:0] o_rdata1,
  output logic [DW-1:0] o_rdata2
);

  logic [DW-1:0] r_mem [NREGS];

  // Clear on reset; otherwise write the addressed entry unless it is r0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem <= '{default: '0};
    end else if (i_we && (i_waddr != '0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = (i_raddr1 == '0) ? '0 : r_mem[i_raddr1];
  assign o_rdata2 = (i_raddr2 == '0) ? '0 : r_mem[i_raddr2];

endmodule : alu_seq_regfile

// File: rtl/alu_op_sequencer.sv
// ALU op sequencer: accepts register-form commands, reads operands from a
// local register file, drives an external combinational ALU for one cycle,
// writes the result back and returns it on a response handshake.
// One command in flight; FSM IDLE -> EXEC -> RESP -> IDLE.
// Optional feature macro ALU_SEQ_ZCNT_EN: adds zero_cnt[15:0], a saturating
// count of accepted responses with rsp_zero=1 and rsp_err=0.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned NREGS = 8,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ALU_OP_W-1:0] cmd_op,
  input  logic [AW-1:0]       cmd_rd,
  input  logic [AW-1:0]       cmd_rs1,
  input  logic [AW-1:0]       cmd_rs2,
  output logic [DW-1:0]       alu_a,
  output logic [DW-1:0]       alu_b,
  output logic [ALU_OP_W-1:0] alu_ctrl,
  input  logic [DW-1:0]       alu_result,
  input  logic                alu_zero,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DW-1:0]       rsp_data,
  output logic                rsp_zero,
  output logic                rsp_err
`ifdef ALU_SEQ_ZCNT_EN
  ,
  output logic [15:0]         zero_cnt
`endif
);

  seq_state_e          r_state;
  logic [DW-1:0]       r_a;
  logic [DW-1:0]       r_b;
  logic [ALU_OP_W-1:0] r_op;
  logic [AW-1:0]       r_rd;
  logic [DW-1:0]       r_res;
  logic                r_zq;
  logic                r_err;

  logic [DW-1:0]       w_rdata1;
  logic [DW-1:0]       w_rdata2;
  logic                w_we;

  // Write back only during EXEC of a legal opcode (bit 3 clear).
  assign w_we = (r_state == EXEC) && !r_op[3];

  alu_seq_regfile #(
    .DW    (DW),
    .NREGS (NREGS)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_we     (w_we),
    .i_waddr  (r_rd),
    .i_wdata  (alu_result),
    .i_raddr1 (cmd_rs1),
    .i_raddr2 (cmd_rs2),
    .o_rdata1 (w_rdata1),
    .o_rdata2 (w_rdata2)
  );

  // Sequencer FSM: latch command/operands, capture ALU result, hold response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_rd    <= '0;
      r_res   <= '0;
      r_zq    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_op    <= cmd_op;
            r_rd    <= cmd_rd;
            r_a     <= w_rdata1;
            r_b     <= w_rdata2;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          if (!r_op[3]) begin
            r_res <= alu_result;
            r_zq  <= alu_zero;
            r_err <= 1'b0;
          end else begin
            r_res <= '0;
            r_zq  <= 1'b1;
            r_err <= 1'b1;
          end
          r_state <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Operand registers only change on command accept, so they already hold
  // their last values outside EXEC and can drive the ALU directly.
  assign alu_a     = r_a;
  assign alu_b     = r_b;
  assign alu_ctrl  = r_op;
  assign cmd_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == RESP);
  assign rsp_data  = r_res;
  assign rsp_zero  = r_zq;
  assign rsp_err   = r_err;

`ifdef ALU_SEQ_ZCNT_EN
  logic [15:0] r_zero_cnt;
  logic        w_rsp_fire;

  assign w_rsp_fire = (r_state == RESP) && rsp_ready;

  // Count legal zero-result responses at handshake, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_zero_cnt <= '0;
    end else if (w_rsp_fire && r_zq && !r_err && (r_zero_cnt != '1)) begin
      r_zero_cnt <= r_zero_cnt + 16'd1;
    end
  end

  assign zero_cnt = r_zero_cnt;
`endif

endmodule : alu_op_sequencer

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer with a behavioural
// combinational ALU attached.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [2:0]  cmd_rd;
  logic [2:0]  cmd_rs1;
  logic [2:0]  cmd_rs2;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_zero;
  logic        rsp_err;
`ifdef ALU_SEQ_ZCNT_EN
  logic [15:0] zero_cnt;
`endif

  int n_cmp;
  int n_fail;

  alu_op_sequencer #(
    .DW    (32),
    .NREGS (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_rd     (cmd_rd),
    .cmd_rs1    (cmd_rs1),
    .cmd_rs2    (cmd_rs2),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err)
`ifdef ALU_SEQ_ZCNT_EN
    ,
    .zero_cnt   (zero_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU; illegal codes yield a junk value the sequencer must mask.
  always_comb begin
    case (alu_ctrl)
      4'd0:    alu_result = alu_a & alu_b;
      4'd1:    alu_result = alu_a | alu_b;
      4'd2:    alu_result = alu_a ^ alu_b;
      4'd3:    alu_result = ~(alu_a | alu_b);
      4'd4:    alu_result = alu_a + alu_b;
      4'd5:    alu_result = alu_a - alu_b;
      4'd6:    alu_result = alu_a + 32'd1;
      4'd7:    alu_result = alu_a - 32'd1;
      default: alu_result = 32'hDEAD_BEEF;
    endcase
  end
  assign alu_zero = (alu_result == 32'd0);

  // Full command/response transaction; bounded waits count as comparisons.
  task automatic issue(input logic [3:0] op, input logic [2:0] rd,
                       input logic [2:0] rs1, input logic [2:0] rs2,
                       output logic [31:0] d, output logic z, output logic e);
    int unsigned w;
    @(negedge clk);
    w = 0;
    while (!cmd_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL issue_cmd_ready_timeout: got %b want 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_rd    = rd;
    cmd_rs1   = rs1;
    cmd_rs2   = rs2;
    @(negedge clk);
    cmd_valid = 1'b0;
    w = 0;
    while (!rsp_valid && w < 10) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (rsp_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL issue_rsp_valid_timeout: got %b want 1", rsp_valid);
    end
    d = rsp_data;
    z = rsp_zero;
    e = rsp_err;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    logic z, e;
    if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
    n_cmp++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++;
    if ({rsp_data, rsp_zero, rsp_err} !== 34'd0) begin
      n_fail++; $display("FAIL rst_rsp_fields: got %h/%b/%b want 0/0/0", rsp_data, rsp_zero, rsp_err);
    end
    n_cmp++;
    if ({alu_a, alu_b, alu_ctrl} !== 68'd0) begin
      n_fail++; $display("FAIL rst_alu_outs: got %h/%h/%h want 0/0/0", alu_a, alu_b, alu_ctrl);
    end
    n_cmp++;
`ifdef ALU_SEQ_ZCNT_EN
    if (zero_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_zero_cnt: got %h want 0", zero_cnt); end
    n_cmp++;
`endif
    // Put a value in r1, then reset in the middle of an ADD into r2.
    issue(INC, 3'd1, 3'd0, 3'd0, d, z, e);
    if (d !== 32'd1) begin n_fail++; $display("FAIL rst_pre_inc: got %h want 1", d); end
    n_cmp++;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = ADD; cmd_rd = 3'd2; cmd_rs1 = 3'd1; cmd_rs2 = 3'd1;
    @(negedge clk);
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_exec: got valid=%b ready=%b want 0/1", rsp_valid, cmd_ready);
    end
    n_cmp++;
    if (alu_a !== 32'd0) begin n_fail++; $display("FAIL rst_mid_alu_a: got %h want 0", alu_a); end
    n_cmp++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_post_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++;
    issue(OR, 3'd0, 3'd1, 3'd1, d, z, e);
    if (d !== 32'd0) begin n_fail++; $display("FAIL rst_r1_cleared: got %h want 0", d); end
    n_cmp++;
    issue(OR, 3'd0, 3'd2, 3'd2, d, z, e);
    if (d !== 32'd0) begin n_fail++; $display("FAIL rst_r2_no_write: got %h want 0", d); end
    n_cmp++;
  endtask

  task automatic test_arith;
    logic [31:0] d;
    logic z, e;
    issue(INC, 3'd1, 3'd0, 3'd0, d, z, e);
    if (d !== 32'd1 || z !== 1'b0 || e !== 1'b0) begin
      n_fail++; $display("FAIL arith_inc0: got %h/%b/%b want 1/0/0", d, z, e);
    end
    n_cmp++;
    issue(INC, 3'd1, 3'd1, 3'd0, d, z, e);
    if (d !== 32'd2) begin n_fail++; $display("FAIL arith_inc1: got %h want 2", d); end
    n_cmp++;
    issue(ADD, 3'd2, 3'd1, 3'd1, d, z, e);
    if (d !== 32'd4) begin n_fail++; $display("FAIL arith_add: got %h want 4", d); end
    n_cmp++;
    issue(OR, 3'd0, 3'd2, 3'd0, d, z, e);
    if (d !== 32'd4) begin n_fail++; $display("FAIL arith_r2: got %h want 4", d); end
    n_cmp++;
  endtask

  task automatic test_wrap;
    logic [31:0] d;
    logic z, e;
`ifdef ALU_SEQ_ZCNT_EN
    logic [15:0] c0;
`endif
    issue(DEC, 3'd3, 3'd0, 3'd0, d, z, e);
    if (d !== 32'hFFFF_FFFF || z !== 1'b0) begin
      n_fail++; $display("FAIL wrap_dec: got %h/%b want ffffffff/0", d, z);
    end
    n_cmp++;
    issue(INC, 3'd4, 3'd3, 3'd0, d, z, e);
    if (d !== 32'd0 || z !== 1'b1 || e !== 1'b0) begin
      n_fail++; $display("FAIL wrap_inc: got %h/%b/%b want 0/1/0", d, z, e);
    end
    n_cmp++;
`ifdef ALU_SEQ_ZCNT_EN
    c0 = zero_cnt;
`endif
    issue(SUB, 3'd5, 3'd2, 3'd2, d, z, e);
    if (d !== 32'd0 || z !== 1'b1) begin
      n_fail++; $display("FAIL wrap_sub: got %h/%b want 0/1", d, z);
    end
    n_cmp++;
`ifdef ALU_SEQ_ZCNT_EN
    if (zero_cnt !== c0 + 16'd1) begin
      n_fail++; $display("FAIL zcnt_inc: got %h want %h", zero_cnt, c0 + 16'd1);
    end
    n_cmp++;
`endif
  endtask

  task automatic test_logic;
    logic [31:0] d;
    logic z, e;
    issue(OR, 3'd0, 3'd1, 3'd2, d, z, e);
    if (d !== 32'd6) begin n_fail++; $display("FAIL logic_or_peek: got %h want 6", d); end
    n_cmp++;
    issue(OR, 3'd6, 3'd1, 3'd2, d, z, e);
    if (d !== 32'd6) begin n_fail++; $display("FAIL logic_or: got %h want 6", d); end
    n_cmp++;
    issue(NOR, 3'd7, 3'd0, 3'd0, d, z, e);
    if (d !== 32'hFFFF_FFFF || z !== 1'b0) begin
      n_fail++; $display("FAIL logic_nor: got %h/%b want ffffffff/0", d, z);
    end
    n_cmp++;
    issue(INC, 3'd0, 3'd2, 3'd0, d, z, e);
    if (d !== 32'd5) begin n_fail++; $display("FAIL logic_inc_rd0: got %h want 5", d); end
    n_cmp++;
    issue(OR, 3'd0, 3'd0, 3'd0, d, z, e);
    if (d !== 32'd0 || z !== 1'b1) begin
      n_fail++; $display("FAIL logic_r0_zero: got %h/%b want 0/1", d, z);
    end
    n_cmp++;
    issue(XOR, 3'd0, 3'd7, 3'd6, d, z, e);
    if (d !== 32'hFFFF_FFF9) begin n_fail++; $display("FAIL logic_xor: got %h want fffffff9", d); end
    n_cmp++;
  endtask

  task automatic test_latency;
    logic [31:0] d;
    logic z, e;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = INC; cmd_rd = 3'd6; cmd_rs1 = 3'd0; cmd_rs2 = 3'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL lat_exec: got valid=%b ready=%b want 0/0", rsp_valid, cmd_ready);
    end
    n_cmp++;
    if (alu_ctrl !== 4'd6) begin n_fail++; $display("FAIL lat_alu_ctrl: got %h want 6", alu_ctrl); end
    n_cmp++;
    @(negedge clk);
    if (rsp_valid !== 1'b1 || rsp_data !== 32'd1) begin
      n_fail++; $display("FAIL lat_resp: got valid=%b data=%h want 1/1", rsp_valid, rsp_data);
    end
    n_cmp++;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    issue(OR, 3'd0, 3'd6, 3'd0, d, z, e);
    if (d !== 32'd1) begin n_fail++; $display("FAIL lat_r6: got %h want 1", d); end
    n_cmp++;
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = ADD; cmd_rd = 3'd1; cmd_rs1 = 3'd1; cmd_rs2 = 3'd2;
    @(negedge clk);
    // A second command is presented early and must wait until IDLE.
    cmd_op = INC; cmd_rd = 3'd3; cmd_rs1 = 3'd1; cmd_rs2 = 3'd0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid !== 1'b1 || rsp_data !== 32'd6 || cmd_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got valid=%b data=%h ready=%b want 1/6/0", i, rsp_valid, rsp_data, cmd_ready);
      end
      n_cmp++;
      if (alu_a !== 32'd2 || alu_b !== 32'd4 || alu_ctrl !== 4'd4) begin
        n_fail++; $display("FAIL bp_alu_hold%0d: got %h/%h/%h want 2/4/4", i, alu_a, alu_b, alu_ctrl);
      end
      n_cmp++;
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_idle: got ready=%b valid=%b want 1/0", cmd_ready, rsp_valid);
    end
    n_cmp++;
    @(negedge clk);
    cmd_valid = 1'b0;
    if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL bp_next_accept: got %b want 0", cmd_ready); end
    n_cmp++;
    @(negedge clk);
    if (rsp_valid !== 1'b1 || rsp_data !== 32'd7) begin
      n_fail++; $display("FAIL bp_next_rsp: got valid=%b data=%h want 1/7", rsp_valid, rsp_data);
    end
    n_cmp++;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_illegal;
    logic [31:0] d;
    logic z, e;
`ifdef ALU_SEQ_ZCNT_EN
    logic [15:0] c0;
    c0 = zero_cnt;
`endif
    issue(4'b1010, 3'd2, 3'd1, 3'd1, d, z, e);
    if (e !== 1'b1 || d !== 32'd0 || z !== 1'b1) begin
      n_fail++; $display("FAIL illegal_rsp: got err=%b data=%h zero=%b want 1/0/1", e, d, z);
    end
    n_cmp++;
`ifdef ALU_SEQ_ZCNT_EN
    if (zero_cnt !== c0) begin n_fail++; $display("FAIL illegal_zcnt: got %h want %h", zero_cnt, c0); end
    n_cmp++;
`endif
    issue(OR, 3'd0, 3'd2, 3'd0, d, z, e);
    if (d !== 32'd4 || e !== 1'b0) begin
      n_fail++; $display("FAIL illegal_r2_kept: got %h/%b want 4/0", d, e);
    end
    n_cmp++;
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_arith();
    test_wrap();
    test_logic();
    test_latency();
    test_backpressure();
    test_illegal();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_alu_op_sequencer
